ingress_acq_ctrl: RTL and testbench

Acquisition sequencer between the dual-channel ADC sample source and the AXI-stream ingress path. It is armed by software and waits for a trigger (immediate, external edge or ch0 threshold). It then captures fixed-length frames of packed {ch1,ch0} words onto an AXI-stream master with tlast framing, inserting holdoff gaps between frames. It also reports state, frame count and dropped-sample count.

---
 rtl/ingress_pkg.sv | 27 ++
 rtl/ingress_out_reg.sv | 44 ++++
 rtl/ingress_acq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ingress_acq_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_pkg.sv
// Shared types and widths for the ADC ingress acquisition path.
// Only the state/trigger encodings and fixed stat counter widths live here.
package ingress_pkg;

  localparam int OVF_W = 16;
  localparam int FRM_W = 8;

  typedef enum logic [2:0] {
    ACQ_IDLE    = 3'd0,
    ACQ_ARMED   = 3'd1,
    ACQ_CAPTURE = 3'd2,
    ACQ_FLUSH   = 3'd3,
    ACQ_HOLDOFF = 3'd4
  } acq_state_e;

  typedef enum logic [1:0] {
    TRIG_IMM = 2'd0,
    TRIG_EXT = 2'd1,
    TRIG_LVL = 2'd2
  } trig_mode_e;

  // Reserved mode 3 behaves as immediate trigger.
  function automatic trig_mode_e trig_decode(input logic [1:0] mode);
    return (mode == 2'd3) ? TRIG_IMM : trig_mode_e'(mode);
  endfunction

endpackage

// File: rtl/ingress_out_reg.sv
// Single-entry AXI-stream output register; beat visible one cycle after load.
// Under backpressure the beat holds stable and o_rdy drops; load and drain may share a cycle.
module ingress_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_last,
  output logic              o_rdy,
  output logic              o_drain,
  output logic              o_m_tvalid,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic              o_m_tlast,
  input  logic              i_m_tready
);

  logic              r_vld;
  logic [DATA_W-1:0] r_dat;
  logic              r_last;

  assign o_rdy   = !r_vld || i_m_tready;
  assign o_drain = r_vld && i_m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_dat  <= i_dat;
      r_last <= i_last;
    end else if (i_m_tready) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_m_tvalid = r_vld;
  assign o_m_tdata  = r_dat;
  assign o_m_tlast  = r_last;

endmodule

// File: rtl/ingress_acq_ctrl.sv
// Acquisition sequencer: arm, trigger, then fixed-length {ch1,ch0} frames onto an AXI-stream master.
// One cycle sample-to-beat; under backpressure the pending beat holds and new samples are dropped and counted.
module ingress_acq_ctrl
  import ingress_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADC_W  = 16,
  parameter int LEN_W  = 16,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_arm,
  input  logic              i_cfg_abort,
  input  logic [1:0]        i_cfg_trig_mode,
  input  logic [ADC_W-1:0]  i_cfg_threshold,
  input  logic [LEN_W-1:0]  i_cfg_frame_len,
  input  logic [FRM_W-1:0]  i_cfg_frames,
  input  logic [HOLD_W-1:0] i_cfg_holdoff,
  input  logic              i_ext_trig,
  input  logic [ADC_W-1:0]  i_adc_ch0,
  input  logic [ADC_W-1:0]  i_adc_ch1,
  input  logic              i_adc_valid,
  output logic              o_m_tvalid,
  input  logic              i_m_tready,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic              o_m_tlast,
  output logic [2:0]        o_stat_state,
  output logic              o_stat_busy,
  output logic [FRM_W-1:0]  o_stat_frame_cnt,
  output logic [OVF_W-1:0]  o_stat_ovf_cnt,
  output logic              o_irq_done
);

  typedef struct packed {
    trig_mode_e        mode;
    logic [ADC_W-1:0]  thr;
    logic [LEN_W-1:0]  len;
    logic [FRM_W-1:0]  frames;
    logic [HOLD_W-1:0] hold;
  } cfg_t;

  acq_state_e        r_state, w_state_nxt;
  cfg_t              r_cfg;
  logic [LEN_W-1:0]  r_beat, w_len_eff;
  logic [FRM_W-1:0]  r_frame_cnt, w_frm_inc;
  logic [OVF_W-1:0]  r_ovf_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic              r_trig_prev, r_irq;
  logic              w_arm_ok, w_beat_last, w_final, w_hold_done;
  logic              w_acc, w_rdy, w_drain, w_load, w_drop;
  logic              w_frame_done, w_irq_nxt;
  logic [DATA_W-1:0] w_dat;

  assign w_dat       = {i_adc_ch1, i_adc_ch0};
  assign w_arm_ok    = (r_state == ACQ_IDLE) && i_cfg_arm && !i_cfg_abort;
  assign w_len_eff   = (r_cfg.len == '0) ? LEN_W'(1) : r_cfg.len;
  assign w_beat_last = (r_beat == w_len_eff - 1'b1);
  assign w_frm_inc   = r_frame_cnt + 1'b1;
  assign w_final     = (r_cfg.frames != '0) && (w_frm_inc == r_cfg.frames);
  assign w_hold_done = (r_hold == r_cfg.hold - 1'b1);
  assign w_load      = w_acc && w_rdy;
  assign w_drop      = w_acc && !w_rdy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ACQ_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Abort outranks everything: no loads, no frame credit, no irq.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc        = 1'b0;
    w_frame_done = 1'b0;
    w_irq_nxt    = 1'b0;
    if (i_cfg_abort) begin
      w_state_nxt = ACQ_IDLE;
    end else begin
      case (r_state)
        ACQ_IDLE: if (i_cfg_arm) w_state_nxt = ACQ_ARMED;
        ACQ_ARMED: begin
          case (r_cfg.mode)
            TRIG_EXT: if (i_ext_trig && !r_trig_prev) w_state_nxt = ACQ_CAPTURE;
            TRIG_LVL: begin
              if (i_adc_valid && (i_adc_ch0 >= r_cfg.thr)) begin
                w_acc       = 1'b1;
                w_state_nxt = (w_rdy && w_beat_last) ? ACQ_FLUSH : ACQ_CAPTURE;
              end
            end
            default: w_state_nxt = ACQ_CAPTURE;
          endcase
        end
        ACQ_CAPTURE: begin
          w_acc = i_adc_valid;
          if (i_adc_valid && w_rdy && w_beat_last) w_state_nxt = ACQ_FLUSH;
        end
        ACQ_FLUSH: begin
          if (w_drain) begin
            w_frame_done = 1'b1;
            if (w_final) begin
              w_state_nxt = ACQ_IDLE;
              w_irq_nxt   = 1'b1;
            end else if (r_cfg.hold == '0) begin
              w_state_nxt = ACQ_ARMED;
            end else begin
              w_state_nxt = ACQ_HOLDOFF;
            end
          end
        end
        ACQ_HOLDOFF: if (w_hold_done) w_state_nxt = ACQ_ARMED;
        default: w_state_nxt = ACQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg       <= '0;
      r_beat      <= '0;
      r_frame_cnt <= '0;
      r_ovf_cnt   <= '0;
      r_hold      <= '0;
      r_trig_prev <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_trig_prev <= i_ext_trig;
      r_irq       <= w_irq_nxt;
      r_hold      <= (r_state == ACQ_HOLDOFF) ? r_hold + 1'b1 : '0;
      if (w_arm_ok) begin
        r_cfg.mode   <= trig_decode(i_cfg_trig_mode);
        r_cfg.thr    <= i_cfg_threshold;
        r_cfg.len    <= i_cfg_frame_len;
        r_cfg.frames <= i_cfg_frames;
        r_cfg.hold   <= i_cfg_holdoff;
        r_beat       <= '0;
        r_frame_cnt  <= '0;
        r_ovf_cnt    <= '0;
      end
      if (w_load) r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
      if (w_drop && (r_ovf_cnt != {OVF_W{1'b1}})) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      if (w_frame_done) r_frame_cnt <= w_frm_inc;
    end
  end

  ingress_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_dat      (w_dat),
    .i_last     (w_beat_last),
    .o_rdy      (w_rdy),
    .o_drain    (w_drain),
    .o_m_tvalid (o_m_tvalid),
    .o_m_tdata  (o_m_tdata),
    .o_m_tlast  (o_m_tlast),
    .i_m_tready (i_m_tready)
  );

  assign o_stat_state     = r_state;
  assign o_stat_busy      = (r_state != ACQ_IDLE);
  assign o_stat_frame_cnt = r_frame_cnt;
  assign o_stat_ovf_cnt   = r_ovf_cnt;
  assign o_irq_done       = r_irq;

endmodule

// File: tb/tb_ingress_acq_ctrl.sv
// Randomized bench for ingress_acq_ctrl against a per-cycle reference built from the acquisition rules.
`timescale 1ns/1ps
module tb_ingress_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cfg_arm, i_cfg_abort, i_ext_trig, i_adc_valid, i_m_tready;
  logic [1:0]  i_cfg_trig_mode;
  logic [15:0] i_cfg_threshold, i_cfg_frame_len, i_adc_ch0, i_adc_ch1;
  logic [7:0]  i_cfg_frames, i_cfg_holdoff;
  logic        o_m_tvalid, o_m_tlast, o_stat_busy, o_irq_done;
  logic [31:0] o_m_tdata;
  logic [2:0]  o_stat_state;
  logic [7:0]  o_stat_frame_cnt;
  logic [15:0] o_stat_ovf_cnt;

  always #5 clk = ~clk;

  ingress_acq_ctrl #(.DATA_W(32), .ADC_W(16), .LEN_W(16), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_cfg_arm(i_cfg_arm), .i_cfg_abort(i_cfg_abort), .i_cfg_trig_mode(i_cfg_trig_mode),
    .i_cfg_threshold(i_cfg_threshold), .i_cfg_frame_len(i_cfg_frame_len),
    .i_cfg_frames(i_cfg_frames), .i_cfg_holdoff(i_cfg_holdoff), .i_ext_trig(i_ext_trig),
    .i_adc_ch0(i_adc_ch0), .i_adc_ch1(i_adc_ch1), .i_adc_valid(i_adc_valid),
    .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready), .o_m_tdata(o_m_tdata),
    .o_m_tlast(o_m_tlast), .o_stat_state(o_stat_state), .o_stat_busy(o_stat_busy),
    .o_stat_frame_cnt(o_stat_frame_cnt), .o_stat_ovf_cnt(o_stat_ovf_cnt),
    .o_irq_done(o_irq_done)
  );

  typedef struct packed { logic last; logic [31:0] dat; } beat_t;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: phase numbers are the reported state codes; the output register is a queue of depth <= 1.
  int    m_ph, m_mode, m_thr, m_len, m_frames, m_hold;
  int    m_beat, m_frm, m_ovf, m_hcnt;
  bit    m_prev, m_irq;
  beat_t mq[$];

  task automatic model_reset();
    m_ph = 0; m_mode = 0; m_thr = 0; m_len = 1; m_frames = 0; m_hold = 0;
    m_beat = 0; m_frm = 0; m_ovf = 0; m_hcnt = 0; m_prev = 0; m_irq = 0;
    mq.delete();
  endtask

  task automatic model_step();
    bit    room, drain, acc, irq_n;
    int    nph;
    beat_t b;
    if (rst) begin
      model_reset();
      return;
    end
    nph = m_ph; acc = 0; irq_n = 0;
    drain = (mq.size() != 0) && i_m_tready;
    room  = (mq.size() == 0) || i_m_tready;
    if (i_cfg_abort) begin
      nph = 0;
    end else if (m_ph == 0) begin
      if (i_cfg_arm) begin
        m_mode = (i_cfg_trig_mode == 2'd3) ? 0 : int'(i_cfg_trig_mode);
        m_thr = int'(i_cfg_threshold);
        m_len = (i_cfg_frame_len == 0) ? 1 : int'(i_cfg_frame_len);
        m_frames = int'(i_cfg_frames);
        m_hold = int'(i_cfg_holdoff);
        m_beat = 0; m_frm = 0; m_ovf = 0;
        nph = 1;
      end
    end else if (m_ph == 1) begin
      if (m_mode == 1) begin
        if (i_ext_trig && !m_prev) nph = 2;
      end else if (m_mode == 2) begin
        if (i_adc_valid && int'(i_adc_ch0) >= m_thr) begin acc = 1; nph = 2; end
      end else begin
        nph = 2;
      end
    end else if (m_ph == 2) begin
      acc = i_adc_valid;
    end else if (m_ph == 3) begin
      if (drain) begin
        m_frm++;
        if (m_frames != 0 && m_frm == m_frames) begin nph = 0; irq_n = 1; end
        else if (m_hold == 0) nph = 1;
        else begin nph = 4; m_hcnt = 0; end
      end
    end else begin
      m_hcnt++;
      if (m_hcnt >= m_hold) nph = 1;
    end
    if (drain) void'(mq.pop_front());
    if (acc) begin
      if (room) begin
        b.dat = {i_adc_ch1, i_adc_ch0};
        b.last = (m_beat == m_len - 1);
        mq.push_back(b);
        if (b.last) begin m_beat = 0; nph = 3; end
        else m_beat++;
      end else if (m_ovf < 65535) begin
        m_ovf++;
      end
    end
    m_prev = i_ext_trig;
    m_ph = nph;
    m_irq = irq_n;
  endtask

  int unsigned p_v = 100, p_r = 100;
  bit          use_ramp = 0, rnd_trig = 0;
  logic [15:0] ramp;
  beat_t       obs[$];
  int          obs_t[$];
  int          n_irq = 0, cyc = 0;

  task automatic drive();
    i_adc_valid = ($urandom_range(99) < p_v);
    i_m_tready  = ($urandom_range(99) < p_r);
    i_adc_ch1   = 16'($urandom);
    if (use_ramp) begin i_adc_ch0 = ramp; ramp = ramp + 16'd8; end
    else i_adc_ch0 = 16'($urandom);
    i_cfg_trig_mode = 2'($urandom);
    i_cfg_threshold = 16'($urandom);
    i_cfg_frame_len = 16'($urandom);
    i_cfg_frames    = 8'($urandom);
    i_cfg_holdoff   = 8'($urandom);
    i_cfg_arm = 1'b0;
    i_cfg_abort = 1'b0;
    if (rnd_trig) i_ext_trig = ($urandom_range(3) == 0);
  endtask

  task automatic cycle();
    chk("state", 64'(o_stat_state), 64'(m_ph));
    chk("busy", 64'(o_stat_busy), 64'(m_ph != 0));
    chk("tvalid", 64'(o_m_tvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("beat", 64'({o_m_tlast, o_m_tdata}), 64'(mq[0]));
    chk("frame_cnt", 64'(o_stat_frame_cnt), 64'(m_frm % 256));
    chk("ovf_cnt", 64'(o_stat_ovf_cnt), 64'(m_ovf));
    chk("irq", 64'(o_irq_done), 64'(m_irq));
    if (o_m_tvalid && i_m_tready) begin
      obs.push_back({o_m_tlast, o_m_tdata});
      obs_t.push_back(cyc);
    end
    if (o_irq_done) n_irq++;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin drive(); cycle(); end
  endtask

  task automatic arm(input int md, input int thr, input int len, input int frm, input int hold);
    drive();
    i_cfg_trig_mode = 2'(md);
    i_cfg_threshold = 16'(thr);
    i_cfg_frame_len = 16'(len);
    i_cfg_frames    = 8'(frm);
    i_cfg_holdoff   = 8'(hold);
    i_cfg_arm = 1'b1;
    cycle();
    i_cfg_arm = 1'b0;
  endtask

  task automatic clear_obs();
    obs.delete(); obs_t.delete(); n_irq = 0;
  endtask

  function automatic logic [63:0] all_outs();
    return {1'b0, o_m_tvalid, o_m_tdata, o_m_tlast, o_stat_state, o_stat_busy,
            o_stat_frame_cnt, o_stat_ovf_cnt, o_irq_done};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    int guard;
    rst = 1'b1; i_ext_trig = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;

    // mode 0, len 4, 2 frames, holdoff 3
    clear_obs();
    arm(0, 0, 4, 2, 3);
    run(30);
    chk("s1_beats", 64'(obs.size()), 64'd8);
    if (obs.size() == 8) begin
      chk("s1_tlast3", 64'(obs[3].last), 64'd1);
      chk("s1_tlast7", 64'(obs[7].last), 64'd1);
      chk("s1_gap_ge3", 64'((obs_t[4] - obs_t[3] - 1) >= 3), 64'd1);
    end
    chk("s1_irq_pulses", 64'(n_irq), 64'd1);
    chk("s1_frames", 64'(o_stat_frame_cnt), 64'd2);
    chk("s1_idle", 64'(o_stat_state), 64'd0);

    // mode 2 threshold on a ch0 ramp
    clear_obs();
    arm(2, 16'h0100, 2, 1, 0);
    use_ramp = 1; ramp = 16'h00F0;
    run(10);
    use_ramp = 0;
    chk("s2_beats", 64'(obs.size()), 64'd2);
    if (obs.size() == 2) begin
      chk("s2_b0_ch0", 64'(obs[0].dat[15:0]), 64'h0100);
      chk("s2_b1_ch0", 64'(obs[1].dat[15:0]), 64'h0108);
      chk("s2_b0_last", 64'(obs[0].last), 64'd0);
      chk("s2_b1_last", 64'(obs[1].last), 64'd1);
    end

    // backpressure: first sample loads, four drop
    clear_obs();
    arm(0, 0, 8, 1, 0);
    run(1);
    p_r = 0;
    run(5);
    chk("s3_held_vld", 64'(o_m_tvalid), 64'd1);
    chk("s3_ovf", 64'(o_stat_ovf_cnt), 64'd4);
    p_r = 100;
    run(15);
    chk("s3_beats", 64'(obs.size()), 64'd8);
    chk("s3_ovf_after", 64'(o_stat_ovf_cnt), 64'd4);

    // external trigger edge, level held high from arm
    clear_obs();
    i_ext_trig = 1'b1;
    arm(1, 0, 3, 1, 0);
    run(5);
    chk("s4_waiting", 64'(o_stat_state), 64'd1);
    chk("s4_no_beats", 64'(obs.size()), 64'd0);
    i_ext_trig = 1'b0;
    run(2);
    i_ext_trig = 1'b1;
    run(1);
    chk("s4_capture", 64'(o_stat_state), 64'd2);
    run(6);
    chk("s4_beats", 64'(obs.size()), 64'd3);
    i_ext_trig = 1'b0;

    // abort with a pending beat under backpressure
    clear_obs();
    arm(0, 0, 4, 1, 0);
    run(3);
    p_r = 0;
    drive();
    i_cfg_abort = 1'b1;
    cycle();
    run(3);
    chk("s5_pending_vld", 64'(o_m_tvalid), 64'd1);
    chk("s5_pending_last", 64'(o_m_tlast), 64'd0);
    chk("s5_idle", 64'(o_stat_state), 64'd0);
    p_r = 100;
    run(3);
    chk("s5_no_irq", 64'(n_irq), 64'd0);
    chk("s5_frames", 64'(o_stat_frame_cnt), 64'd0);
    chk("s5_drained", 64'(o_m_tvalid), 64'd0);

    // continuous single-beat frames, counter wrap
    arm(0, 0, 1, 0, 0);
    guard = 0;
    while (m_frm < 300 && guard < 1500) begin drive(); cycle(); guard++; end
    chk("s6_in_time", 64'(guard < 1500), 64'd1);
    chk("s6_wrap", 64'(o_stat_frame_cnt), 64'd44);
    chk("s6_still_busy", 64'(o_stat_busy), 64'd1);
    drive(); i_cfg_abort = 1'b1; cycle();
    run(3);
    chk("s6_aborted", 64'(o_stat_state), 64'd0);

    // reset mid-frame
    arm(0, 0, 5, 0, 0);
    run(3);
    rst = 1'b1;
    drive();
    cycle();
    rst = 1'b0;
    chk("rst_mid_frame", all_outs(), 64'd0);
    run(3);

    // randomized configs, triggers, aborts and re-arms
    rnd_trig = 1;
    for (int it = 0; it < 40; it++) begin
      p_v = $urandom_range(100, 30);
      p_r = $urandom_range(100, 30);
      arm($urandom_range(3), $urandom_range(16'hFFFF), $urandom_range(5),
          $urandom_range(3), $urandom_range(3));
      for (int k = 0; k < 60; k++) begin
        drive();
        if ($urandom_range(99) < 2) i_cfg_abort = 1'b1;
        if ($urandom_range(99) < 3) i_cfg_arm = 1'b1;
        cycle();
      end
      drive(); i_cfg_abort = 1'b1; cycle();
      p_r = 100;
      run(4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
